// File: rtl/div_ctrl.sv
// Multi-cycle RV32M divide/remainder sequencer: restoring shift-subtract divider
// that stalls the pipeline while it iterates and pulses ready with the result.
module div_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [XLEN-1:0]  dividend_i,
    input  logic [XLEN-1:0]  divisor_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_req_o,
    output logic             ready_o,
    output logic [XLEN-1:0]  result_o,
    output logic [4:0]       rd_addr_o,
    output logic             regs_wen_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_rem_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic [XLEN-1:0]  quot_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  result_hold_q;
    logic [4:0]       rd_addr_q;
    logic [4:0]       rd_addr_hold_q;

    logic             signed_op;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [XLEN-1:0]  dvd_mag;
    logic [XLEN-1:0]  dvs_mag;
    logic             div_by_zero;
    logic             overflow;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;
    logic             fits;
    logic [XLEN-1:0]  quot_final;
    logic [XLEN-1:0]  rem_final;
    logic [XLEN-1:0]  done_result;

    always_comb begin
        signed_op   = ~op_i[0];
        dvd_neg     = signed_op & dividend_i[XLEN-1];
        dvs_neg     = signed_op & divisor_i[XLEN-1];
        dvd_mag     = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
        dvs_mag     = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
        div_by_zero = (divisor_i == '0);
        overflow    = signed_op && (dividend_i == MIN_NEG) && (divisor_i == '1);

        // One restoring step: shift {rem, quot} left and trial-subtract with a borrow bit.
        shifted     = {rem_q, quot_q[XLEN-1]};
        diff        = shifted - {1'b0, dvs_q};
        fits        = ~diff[XLEN];

        quot_final  = neg_q_q ? (~quot_q + 1'b1) : quot_q;
        rem_final   = neg_r_q ? (~rem_q + 1'b1) : rem_q;
        done_result = is_rem_q ? rem_final : quot_final;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            is_rem_q       <= 1'b0;
            neg_q_q        <= 1'b0;
            neg_r_q        <= 1'b0;
            quot_q         <= '0;
            dvs_q          <= '0;
            rem_q          <= '0;
            result_hold_q  <= '0;
            rd_addr_q      <= '0;
            rd_addr_hold_q <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        is_rem_q  <= op_i[1];
                        rd_addr_q <= rd_addr_i;
                        cnt_q     <= '0;
                        // Fast paths preload the final quotient/remainder and skip negation.
                        if (div_by_zero) begin
                            quot_q  <= '1;
                            rem_q   <= dividend_i;
                            dvs_q   <= '0;
                            neg_q_q <= 1'b0;
                            neg_r_q <= 1'b0;
                            state_q <= DONE;
                        end else if (overflow) begin
                            quot_q  <= MIN_NEG;
                            rem_q   <= '0;
                            dvs_q   <= '0;
                            neg_q_q <= 1'b0;
                            neg_r_q <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            quot_q  <= dvd_mag;
                            dvs_q   <= dvs_mag;
                            rem_q   <= '0;
                            neg_q_q <= dvd_neg ^ dvs_neg;
                            neg_r_q <= dvd_neg;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                    quot_q <= {quot_q[XLEN-2:0], fits};
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    result_hold_q  <= done_result;
                    rd_addr_hold_q <= rd_addr_q;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        stall_req_o = ((state_q == IDLE) && start_i && !flush_i) || (state_q == CALC);
        ready_o     = (state_q == DONE) && !flush_i;
        regs_wen_o  = ready_o;
        result_o    = (state_q == DONE) ? done_result : result_hold_q;
        rd_addr_o   = (state_q == DONE) ? rd_addr_q : rd_addr_hold_q;
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl: directed RV32M corner cases plus random operations
// checked against an arithmetic reference model.
module tb_div_ctrl;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            busy_o;
    logic            stall_req_o;
    logic            ready_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_addr_o;
    logic            regs_wen_o;

    int tests  = 0;
    int failed = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_ctrl #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .rd_addr_i  (rd_addr_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .stall_req_o(stall_req_o),
        .ready_o    (ready_o),
        .result_o   (result_o),
        .rd_addr_o  (rd_addr_o),
        .regs_wen_o (regs_wen_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V M-extension semantics; SV signed division truncates toward zero like RV32M.
    function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int model_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives a start in the current cycle (cycle 0) and returns at the cycle-1 sample point.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        rd_addr_i  = rd;
        #1;
        checkEq("stall_cycle0", {31'd0, stall_req_o}, 32'd1);
        @(negedge clk);
        start_i    = 1'b0;
        op_i       = 2'($urandom);
        dividend_i = $urandom;
        divisor_i  = $urandom;
        rd_addr_i  = 5'($urandom);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_rd, input int exp_lat);
        int cyc;
        int stalls;
        cyc    = 1;
        stalls = 1;
        while (ready_o !== 1'b1 && cyc < 60) begin
            if (stall_req_o === 1'b1) stalls++;
            @(negedge clk);
            cyc++;
        end
        checkEq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        checkEq({tag, "_result"}, result_o, exp_res);
        checkEq({tag, "_rd_addr"}, {27'd0, rd_addr_o}, {27'd0, exp_rd});
        checkEq({tag, "_wen"}, {31'd0, regs_wen_o}, 32'd1);
        checkEq({tag, "_stall_done"}, {31'd0, stall_req_o}, 32'd0);
        checkEq({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
    endtask

    task automatic runCase(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        applyStimulus(op, a, b, rd);
        checkOutput(tag, model_result(op, a, b), rd, model_latency(op, a, b));
        @(negedge clk);
        checkEq({tag, "_pulse_end"}, {31'd0, ready_o}, 32'd0);
    endtask

    initial begin
        logic       saw_ready;
        logic [1:0] rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst        = 1'b1;
        start_i    = 1'b0;
        op_i       = 2'b00;
        dividend_i = '0;
        divisor_i  = '0;
        rd_addr_i  = '0;
        flush_i    = 1'b0;
        repeat (2) @(negedge clk);
        checkEq("reset_busy", {31'd0, busy_o}, 32'd0);
        checkEq("reset_ready", {31'd0, ready_o}, 32'd0);
        checkEq("reset_result", result_o, 32'd0);
        checkEq("reset_rd", {27'd0, rd_addr_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        runCase("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd11);
        runCase("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd12);
        runCase("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd13);
        runCase("remu_m7_2", OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd14);
        runCase("divu_5_0", OP_DIVU, 32'd5, 32'd0, 5'd15);
        runCase("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd16);
        runCase("rem_5_0", OP_REM, 32'd5, 32'd0, 5'd17);
        runCase("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18);
        runCase("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19);
        runCase("div_min_3", OP_DIV, 32'h8000_0000, 32'd3, 5'd20);

        // Flush at cycle 10 aborts the divide; a new start at cycle 12 finishes at cycle 45.
        saw_ready = 1'b0;
        applyStimulus(OP_DIVU, 32'd1000, 32'd3, 5'd5);
        repeat (9) begin
            saw_ready |= ready_o;
            @(negedge clk);
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        saw_ready |= ready_o;
        checkEq("flush_idle", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        saw_ready |= ready_o;
        checkEq("flush_no_ready", {31'd0, saw_ready}, 32'd0);
        runCase("after_flush", OP_DIVU, 32'd100, 32'd7, 5'd9);

        // A flush during DONE must swallow the ready pulse and the write enable.
        applyStimulus(OP_DIVU, 32'd5, 32'd0, 5'd3);
        flush_i = 1'b1;
        #1;
        checkEq("flush_done_ready", {31'd0, ready_o}, 32'd0);
        checkEq("flush_done_wen", {31'd0, regs_wen_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        checkEq("flush_done_idle", {31'd0, busy_o}, 32'd0);

        // Reset at cycle 20 of a DIV clears everything and never produces a result.
        applyStimulus(OP_DIV, 32'hFFFF_FC18, 32'd7, 5'd4);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkEq("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        checkEq("rst_mid_stall", {31'd0, stall_req_o}, 32'd0);
        checkEq("rst_mid_ready", {31'd0, ready_o}, 32'd0);
        checkEq("rst_mid_result", result_o, 32'd0);
        checkEq("rst_mid_rd", {27'd0, rd_addr_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: second start in the IDLE cycle right after DONE (ready at 33 and 67).
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd1);
        checkOutput("b2b_first", 32'd14, 5'd1, 33);
        @(negedge clk);
        checkEq("b2b_gap_ready", {31'd0, ready_o}, 32'd0);
        applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2);
        checkOutput("b2b_second", 32'hFFFF_FFFF, 5'd2, 33);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 15);
                3: rb = -$urandom_range(1, 15);
                default: ;
            endcase
            runCase($sformatf("rand%0d", i), rop, ra, rb, 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
